// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the 800x600@72Hz display path.
// Produces hcount/vcount plus hsync/vsync/blank and line/frame strobes.
// Optional build macro VGA_ALIGN_EN: adds one free-running register stage on
// hsync/vsync/blank so they line up with the one-cycle registered pixel path.
module vga_timing_gen #(
    parameter int   H_VIS  = 800,
    parameter int   H_FP   = 56,
    parameter int   H_SYNC = 120,
    parameter int   H_BP   = 64,
    parameter int   V_VIS  = 600,
    parameter int   V_FP   = 37,
    parameter int   V_SYNC = 6,
    parameter int   V_BP   = 23,
    parameter logic H_POL  = 1'b1,
    parameter logic V_POL  = 1'b1
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_end,
    output logic        frame_end
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Raster sizes must fit the counter widths; stop elaboration otherwise.
    if (H_TOTAL > 2048) begin : g_h_range
        $error("vga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_v_range
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_W   = 11'(H_VIS);
    localparam logic [10:0] H_SYNC_LO = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0]  V_SYNC_LO = 10'(V_VIS + V_FP);
    localparam logic [9:0]  V_SYNC_HI = 10'(V_VIS + V_FP + V_SYNC);

    logic [10:0] hcount_nxt_s;
    logic [9:0]  vcount_nxt_s;
    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        hsync_nxt_s;
    logic        vsync_nxt_s;
    logic        blank_nxt_s;
    logic        line_end_nxt_s;
    logic        frame_end_nxt_s;
    logic        hsync_r;
    logic        vsync_r;
    logic        blank_r;

    // Next raster position and strobes; sync/blank are decoded from the next
    // position so the registered outputs describe the same pixel as the counters.
    always_comb begin
        hcount_nxt_s    = hcount;
        vcount_nxt_s    = vcount;
        h_wrap_s        = (hcount == H_LAST);
        v_wrap_s        = (vcount == V_LAST);
        line_end_nxt_s  = 1'b0;
        frame_end_nxt_s = 1'b0;
        if (pix_en) begin
            line_end_nxt_s  = h_wrap_s;
            frame_end_nxt_s = h_wrap_s & v_wrap_s;
            if (h_wrap_s) begin
                hcount_nxt_s = 11'd0;
                if (v_wrap_s) begin
                    vcount_nxt_s = 10'd0;
                end else begin
                    vcount_nxt_s = vcount + 10'd1;
                end
            end else begin
                hcount_nxt_s = hcount + 11'd1;
            end
        end else begin
            hcount_nxt_s = hcount;
        end
        hsync_nxt_s = ((hcount_nxt_s >= H_SYNC_LO) && (hcount_nxt_s < H_SYNC_HI)) ? H_POL : ~H_POL;
        vsync_nxt_s = ((vcount_nxt_s >= V_SYNC_LO) && (vcount_nxt_s < V_SYNC_HI)) ? V_POL : ~V_POL;
        blank_nxt_s = (hcount_nxt_s >= H_VIS_W) || (vcount_nxt_s >= V_VIS_W);
    end

    // Counter, strobe and first-stage sync/blank registers.
    always_ff @(posedge vclk) begin
        if (rst) begin
            hcount    <= 11'd0;
            vcount    <= 10'd0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            hsync_r   <= ~H_POL;
            vsync_r   <= ~V_POL;
            blank_r   <= 1'b0;
        end else begin
            hcount    <= hcount_nxt_s;
            vcount    <= vcount_nxt_s;
            line_end  <= line_end_nxt_s;
            frame_end <= frame_end_nxt_s;
            hsync_r   <= hsync_nxt_s;
            vsync_r   <= vsync_nxt_s;
            blank_r   <= blank_nxt_s;
        end
    end

`ifdef VGA_ALIGN_EN
    // Alignment stage: delays sync/blank one vclk, runs regardless of pix_en.
    always_ff @(posedge vclk) begin
        if (rst) begin
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            blank <= 1'b0;
        end else begin
            hsync <= hsync_r;
            vsync <= vsync_r;
            blank <= blank_r;
        end
    end
`else
    assign hsync = hsync_r;
    assign vsync = vsync_r;
    assign blank = blank_r;
`endif

endmodule
